// File: rtl/microwave_controller.sv
// Microwave cook timer: keypad M:SS entry, 1 s countdown, 7-segment display, magnetron enable.
// Optional MICROWAVE_BLANK_LEADING_ZERO_EN blanks leading zero minute / tens digits.
module microwave_controller #(
   parameter int CLK_HZ = 100
) (
   input  logic       clock,
   input  logic       clearn,
   input  logic [9:0] keypad,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_closed,
   output logic [6:0] sec_ones_segs,
   output logic [6:0] sec_tens_segs,
   output logic [6:0] min_segs,
   output logic       mag_on
);

   localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(CLK_HZ - 1);

   typedef enum logic [1:0] {IDLE, COOK, PAUSE} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    min_reg, min_next;
   logic [3:0]    tens_reg, tens_next;
   logic [3:0]    ones_reg, ones_next;
   logic [TW-1:0] tick_reg, tick_next;
   logic [9:0]    prev_keypad_reg;
   logic          prev_startn_reg;
   logic          prev_stopn_reg;

   logic       key_press;
   logic [3:0] key_digit;
   logic       start_press;
   logic       stop_press;
   logic       time_zero;
   logic [3:0] dec_min, dec_tens, dec_ones;
   logic       dec_zero;

   // A press needs exactly one key down now and none down on the previous sample.
   assign key_press = (keypad != 10'd0) &&
                      ((keypad & (keypad - 10'd1)) == 10'd0) &&
                      (prev_keypad_reg == 10'd0);

   always_comb begin
      key_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (keypad[i]) key_digit = 4'(i);
      end
   end

   assign start_press = prev_startn_reg & ~startn;
   assign stop_press  = prev_stopn_reg & ~stopn;
   assign time_zero   = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd0);

   always_comb begin
      dec_min  = min_reg;
      dec_tens = tens_reg;
      dec_ones = ones_reg;
      if (ones_reg != 4'd0) begin
         dec_ones = ones_reg - 4'd1;
      end else if (tens_reg != 4'd0) begin
         dec_tens = tens_reg - 4'd1;
         dec_ones = 4'd9;
      end else begin
         dec_min  = min_reg - 4'd1;
         dec_tens = 4'd5;
         dec_ones = 4'd9;
      end
   end

   assign dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

   always_comb begin
      state_next = state_reg;
      min_next   = min_reg;
      tens_next  = tens_reg;
      ones_next  = ones_reg;
      tick_next  = tick_reg;
      case (state_reg)
         IDLE: begin
            if (stop_press) begin
               min_next  = 4'd0;
               tens_next = 4'd0;
               ones_next = 4'd0;
            end else if (start_press && door_closed && !time_zero) begin
               state_next = COOK;
               tick_next  = '0;
            end else if (key_press) begin
               min_next  = tens_reg;
               tens_next = ones_reg;
               ones_next = key_digit;
            end
         end
         COOK: begin
            // Stop beats a simultaneous start; an open door pauses on the same edge.
            if (stop_press || !door_closed) begin
               state_next = PAUSE;
            end else if (tick_reg == TICK_MAX) begin
               tick_next = '0;
               min_next  = dec_min;
               tens_next = dec_tens;
               ones_next = dec_ones;
               if (dec_zero) state_next = IDLE;
            end else begin
               tick_next = tick_reg + 1'b1;
            end
         end
         PAUSE: begin
            if (stop_press) begin
               state_next = IDLE;
               min_next   = 4'd0;
               tens_next  = 4'd0;
               ones_next  = 4'd0;
            end else if (start_press && door_closed) begin
               state_next = COOK;
               tick_next  = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         state_reg       <= IDLE;
         min_reg         <= 4'd0;
         tens_reg        <= 4'd0;
         ones_reg        <= 4'd0;
         tick_reg        <= '0;
         prev_keypad_reg <= 10'd0;
         prev_startn_reg <= 1'b1;
         prev_stopn_reg  <= 1'b1;
      end else begin
         state_reg       <= state_next;
         min_reg         <= min_next;
         tens_reg        <= tens_next;
         ones_reg        <= ones_next;
         tick_reg        <= tick_next;
         prev_keypad_reg <= keypad;
         prev_startn_reg <= startn;
         prev_stopn_reg  <= stopn;
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0111111;
         4'd1:    seg7 = 7'b0000110;
         4'd2:    seg7 = 7'b1011011;
         4'd3:    seg7 = 7'b1001111;
         4'd4:    seg7 = 7'b1100110;
         4'd5:    seg7 = 7'b1101101;
         4'd6:    seg7 = 7'b1111101;
         4'd7:    seg7 = 7'b0000111;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1101111;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   assign sec_ones_segs = seg7(ones_reg);
`ifdef MICROWAVE_BLANK_LEADING_ZERO_EN
   assign min_segs      = (min_reg == 4'd0) ? 7'b0000000 : seg7(min_reg);
   assign sec_tens_segs = (min_reg == 4'd0 && tens_reg == 4'd0) ? 7'b0000000 : seg7(tens_reg);
`else
   assign min_segs      = seg7(min_reg);
   assign sec_tens_segs = seg7(tens_reg);
`endif

   assign mag_on = (state_reg == COOK) && door_closed;

endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller: entry, countdown, borrow, pause/door, guards.
module tb_microwave_controller;

   logic       clock = 1'b0;
   logic       clearn;
   logic [9:0] keypad;
   logic       startn;
   logic       stopn;
   logic       door_closed;
   logic [6:0] sec_ones_segs;
   logic [6:0] sec_tens_segs;
   logic [6:0] min_segs;
   logic       mag_on;

   int n_compared = 0;
   int n_mismatched = 0;

   microwave_controller #(.CLK_HZ(100)) dut (
      .clock         (clock),
      .clearn        (clearn),
      .keypad        (keypad),
      .startn        (startn),
      .stopn         (stopn),
      .door_closed   (door_closed),
      .sec_ones_segs (sec_ones_segs),
      .sec_tens_segs (sec_tens_segs),
      .min_segs      (min_segs),
      .mag_on        (mag_on)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] tab [10];
      tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
      return tab[d];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic check_disp(input string tag, input int m, input int t, input int o);
      logic [6:0] em, et;
      em = seg_of(m);
      et = seg_of(t);
`ifdef MICROWAVE_BLANK_LEADING_ZERO_EN
      if (m == 0) em = 7'b0;
      if (m == 0 && t == 0) et = 7'b0;
`endif
      check({tag, ".min"}, 32'(min_segs), 32'(em));
      check({tag, ".tens"}, 32'(sec_tens_segs), 32'(et));
      check({tag, ".ones"}, 32'(sec_ones_segs), 32'(seg_of(o)));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press_key(input int d);
      keypad = 10'(1 << d);
      step(1);
      keypad = 10'd0;
      step(1);
   endtask

   task automatic press_stop();
      stopn = 1'b0;
      step(1);
      stopn = 1'b1;
      step(1);
   endtask

   // Leaves the controller one edge after the start press was sampled.
   task automatic press_start();
      startn = 1'b0;
      step(1);
      startn = 1'b1;
   endtask

   initial begin
      clearn      = 1'b0;
      keypad      = 10'(1 << 3);
      startn      = 1'b0;
      stopn       = 1'b1;
      door_closed = 1'b1;
      step(3);
      check_disp("reset", 0, 0, 0);
      check("reset.mag", 32'(mag_on), 32'd0);
      keypad = 10'd0;
      startn = 1'b1;
      step(1);
      clearn = 1'b1;
      step(1);

      press_key(3);
      press_key(1);
      press_key(5);
      check_disp("entry315", 3, 1, 5);

      keypad = 10'b0000000101;
      step(2);
      keypad = 10'd0;
      step(1);
      check_disp("multikey", 3, 1, 5);

      keypad = 10'(1 << 7);
      step(3);
      keypad = 10'd0;
      step(1);
      check_disp("heldkey", 1, 5, 7);

      press_stop();
      check_disp("idle_stop", 0, 0, 0);

      press_start();
      check("start_zero.mag", 32'(mag_on), 32'd0);
      step(1);

      press_key(5);
      door_closed = 1'b0;
      press_start();
      step(100);
      door_closed = 1'b1;
      step(1);
      check("start_dooropen.mag", 32'(mag_on), 32'd0);
      check_disp("start_dooropen", 0, 0, 5);

      press_start();
      check("cook.mag_on", 32'(mag_on), 32'd1);
      step(99);
      check_disp("cook99", 0, 0, 5);
      step(1);
      check_disp("cook100", 0, 0, 4);
      step(400);
      check_disp("cook500", 0, 0, 0);
      check("cook_done.mag", 32'(mag_on), 32'd0);
      press_key(2);
      check_disp("done_idle_key", 0, 0, 2);

      press_stop();
      press_key(1);
      press_key(0);
      press_key(0);
      check_disp("entry100", 1, 0, 0);
      press_start();
      step(100);
      check_disp("borrow_min", 0, 5, 9);
      press_stop();
      check("stop_cook.mag", 32'(mag_on), 32'd0);
      check_disp("paused", 0, 5, 9);
      press_stop();
      check_disp("pause_stop", 0, 0, 0);

      press_key(1);
      press_key(0);
      press_start();
      step(100);
      check_disp("borrow_tens", 0, 0, 9);
      step(50);
      door_closed = 1'b0;
      #1;
      check("door_open.mag", 32'(mag_on), 32'd0);
      step(200);
      check_disp("door_frozen", 0, 0, 9);
      door_closed = 1'b1;
      step(1);
      check("door_closed_pause.mag", 32'(mag_on), 32'd0);
      press_start();
      check("resume.mag", 32'(mag_on), 32'd1);
      step(99);
      check_disp("resume99", 0, 0, 9);
      step(1);
      check_disp("resume100", 0, 0, 8);

      startn = 1'b0;
      stopn  = 1'b0;
      step(1);
      startn = 1'b1;
      stopn  = 1'b1;
      check("startstop.mag", 32'(mag_on), 32'd0);
      step(150);
      check_disp("startstop_frozen", 0, 0, 8);
      press_stop();
      check_disp("final_clear", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
